// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch front end: reads a little-endian 32-bit instruction one byte per
//   cycle from a byte-wide synchronous memory, reassembles it and offers it
//   to decode together with its byte address. Branch/jump resolution can
//   redirect the fetch address at any time.
//
//   Optional feature macro: IFU_ALIGN_CHECK_EN
//     defined   : a misaligned redirect target sets the sticky fetch_fault and
//                 parks the unit until reset.
//     undefined : redirect_pc[1:0] is forced to 00 and fetch_fault stays 0.
//
//   Ports
//     clk, reset      rising-edge clock, asynchronous active-high reset
//     mem_en/mem_addr byte read request (registered)
//     mem_rdata       read byte, valid the cycle after its request
//     instr_valid/instr_ready/instr/instr_pc  decode handshake
//     redirect_valid/redirect_pc  new fetch address
//     fetch_fault     sticky misaligned-redirect flag
//
//   Handshake: instr/instr_pc are held stable while instr_valid is high; a
//   word transfers on the clock edge where instr_valid && instr_ready, and
//   instr_ready is ignored while instr_valid is low.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_fault
);

  // The state register names what the unit does at the next clock edge:
  // ISSUE drives the byte request for the following cycle, CAPTURE is the
  // request-free cycle where the last byte is still returning, HOLD presents
  // the word (or raises instr_valid on its first visit).
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // Requests take two edges to come back: the request register is loaded on
  // one edge, the memory registers the byte on the next, and the byte is
  // captured on the edge after that. Two tag stages track which lane is due.
  logic                  req1_v_q, req1_v_d;
  logic [1:0]            req1_lane_q, req1_lane_d;
  logic                  req2_v_q, req2_v_d;
  logic [1:0]            req2_lane_q, req2_lane_d;

  logic                  mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic                  instr_valid_d;
  logic [31:0]           instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_d;
  logic                  fault_d;
  logic [ADDR_WIDTH-1:0] target;
  logic                  redirect_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ISSUE;
      idx_q       <= 2'd0;
      pc_q        <= RESET_PC;
      req1_v_q    <= 1'b0;
      req1_lane_q <= 2'd0;
      req2_v_q    <= 1'b0;
      req2_lane_q <= 2'd0;
      mem_en      <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      req1_v_q    <= req1_v_d;
      req1_lane_q <= req1_lane_d;
      req2_v_q    <= req2_v_d;
      req2_lane_q <= req2_lane_d;
      mem_en      <= mem_en_d;
      mem_addr    <= mem_addr_d;
      instr_valid <= instr_valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      fetch_fault <= fault_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pc_d          = pc_q;
    req1_v_d      = 1'b0;
    req1_lane_d   = req1_lane_q;
    req2_v_d      = req1_v_q;
    req2_lane_d   = req1_lane_q;
    mem_en_d      = 1'b0;
    mem_addr_d    = mem_addr;
    instr_valid_d = instr_valid;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    fault_d       = fetch_fault;

`ifdef IFU_ALIGN_CHECK_EN
    target       = redirect_pc;
    redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    target       = redirect_pc & ~ADDR_WIDTH'(3);
    redirect_bad = 1'b0;
`endif

    if (fetch_fault) begin
      // Parked until reset; redirects and handshakes are ignored.
      instr_valid_d = 1'b0;
      req2_v_d      = 1'b0;
    end else if (redirect_valid && redirect_bad) begin
      fault_d       = 1'b1;
      instr_valid_d = 1'b0;
      req2_v_d      = 1'b0;
    end else if (redirect_valid) begin
      // Start the new word immediately; bytes still in flight from the old
      // address are dropped by clearing both tag stages.
      pc_d          = target;
      mem_en_d      = 1'b1;
      mem_addr_d    = target;
      req1_v_d      = 1'b1;
      req1_lane_d   = 2'd0;
      req2_v_d      = 1'b0;
      idx_d         = 2'd1;
      state_d       = ISSUE;
      instr_valid_d = 1'b0;
    end else begin
      if (req2_v_q) begin
        instr_d[{req2_lane_q, 3'b000} +: 8] = mem_rdata;
      end
      case (state_q)
        ISSUE: begin
          mem_en_d    = 1'b1;
          mem_addr_d  = pc_q + ADDR_WIDTH'(idx_q);
          req1_v_d    = 1'b1;
          req1_lane_d = idx_q;
          idx_d       = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (instr_valid && instr_ready) begin
            // Accepted: the first request of the next word goes out now.
            pc_d          = pc_q + ADDR_WIDTH'(4);
            mem_en_d      = 1'b1;
            mem_addr_d    = pc_q + ADDR_WIDTH'(4);
            req1_v_d      = 1'b1;
            req1_lane_d   = 2'd0;
            idx_d         = 2'd1;
            state_d       = ISSUE;
            instr_valid_d = 1'b0;
          end else begin
            // The last byte lands on this same edge, so the word is complete.
            instr_valid_d = 1'b1;
            instr_pc_d    = pc_q;
          end
        end
        default: begin
          state_d = ISSUE;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int          AW     = 10;
  localparam logic [9:0]  RST_PC = 10'h000;

  logic          clk;
  logic          reset;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          fetch_fault;

  int n_cmp;
  int n_bad;

  logic [7:0]  mem [0:1023];
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous byte memory; garbage on idle cycles so stray captures show.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [9:0] pc);
    logic [9:0] a0, a1, a2, a3;
    a0 = pc;
    a1 = pc + 10'd1;
    a2 = pc + 10'd2;
    a3 = pc + 10'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a0]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model + compare ----------------
  // Model: a word started in cycle s requests pc+0..pc+3 in cycles s..s+3,
  // is visible from cycle s+5 until accepted or redirected.
  logic [9:0]  m_pc;
  int          m_d;
  bit          m_fault;
  bit          m_valid;
  bit          last_valid;
  logic [31:0] last_instr;

  always @(posedge clk) begin
    if (reset) begin
      m_pc       = RST_PC;
      m_d        = -1;
      m_fault    = 1'b0;
      last_valid = 1'b0;
      exp_q.delete();
    end else begin
      m_valid = !m_fault && (m_d >= 5);
      if (m_valid && instr_ready) exp_q.push_back(exp_word(m_pc));
      if (last_valid && instr_ready) begin
        if (exp_q.size() == 0) chk("accept_unexpected", 32'd1, 32'd0);
        else chk("accepted_word", last_instr, exp_q.pop_front());
      end
      if (!m_fault && redirect_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
        else begin
          m_pc = redirect_pc;
          m_d  = 0;
        end
`else
        m_pc = {redirect_pc[9:2], 2'b00};
        m_d  = 0;
`endif
      end else if (m_valid && instr_ready) begin
        m_pc = m_pc + 10'd4;
        m_d  = 0;
      end else if (m_d < 1000) begin
        m_d++;
      end
      #2;
      if (!reset) begin
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("mem_en", {31'd0, mem_en}, {31'd0, (!m_fault && m_d >= 0 && m_d <= 3)});
        if (!m_fault && m_d >= 0 && m_d <= 3)
          chk("mem_addr", {22'd0, mem_addr}, {22'd0, m_pc + m_d[9:0]});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, (!m_fault && m_d >= 5)});
        if (!m_fault && m_d >= 5) begin
          chk("instr", instr, exp_word(m_pc));
          chk("instr_pc", {22'd0, instr_pc}, {22'd0, m_pc});
        end
        last_valid = instr_valid;
        last_instr = instr;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic redirect_to(input logic [9:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h50; mem[3] = 8'h00;
    mem[10'h3FC] = 8'hEF; mem[10'h3FD] = 8'h00;
    mem[10'h3FE] = 8'h00; mem[10'h3FF] = 8'h00;

    reset          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step(3);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_addr}, 32'h0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", {22'd0, instr_pc}, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;

    // Basic fetch: cycle 0 requests address 0, word valid in cycle 5.
    step(1);
    chk("basic_c0_en", {31'd0, mem_en}, 32'd1);
    chk("basic_c0_addr", {22'd0, mem_addr}, 32'h0);
    step(5);
    chk("basic_c5_valid", {31'd0, instr_valid}, 32'd1);
    chk("basic_c5_instr", instr, 32'h00500513);
    chk("basic_c5_pc", {22'd0, instr_pc}, 32'h0);
    step(1);
    chk("basic_c6_addr", {22'd0, mem_addr}, 32'h4);

    // Stall: decode busy well past the next word becoming valid.
    instr_ready = 1'b0;
    step(16);
    instr_ready = 1'b1;
    step(8);

    // Wrap at top of memory.
    redirect_to(10'h3FC);
    step(5);
    chk("wrap_instr", instr, 32'h000000EF);
    chk("wrap_pc", {22'd0, instr_pc}, 32'h3FC);
    step(1);
    chk("wrap_next_addr", {22'd0, mem_addr}, 32'h000);
    step(3);

    // Mid-word redirect during byte index 2 of the word at 0x008.
    redirect_to(10'h008);
    step(2);
    chk("mid_idx2_addr", {22'd0, mem_addr}, 32'h00A);
    redirect_to(10'h020);
    chk("mid_redirect_addr", {22'd0, mem_addr}, 32'h020);
    step(5);
    chk("mid_first_pc", {22'd0, instr_pc}, 32'h020);

    // Simultaneous acceptance and redirect while holding 0x010.
    instr_ready = 1'b0;
    redirect_to(10'h010);
    step(6);
    instr_ready = 1'b1;
    redirect_to(10'h040);
    step(5);
    chk("accept_redirect_pc", {22'd0, instr_pc}, 32'h040);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 10'($urandom_range(0, 1023));
`ifdef IFU_ALIGN_CHECK_EN
        redirect_pc[1:0] = 2'b00;
`endif
      end else begin
        redirect_valid = 1'b0;
      end
      step(1);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;

    // Asynchronous reset in the middle of a word.
    redirect_to(10'h100);
    step(1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_en", {31'd0, mem_en}, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_addr", {22'd0, mem_addr}, 32'h0);
    step(2);
    reset = 1'b0;
    step(12);

    // Misaligned redirect.
    redirect_to(10'h042);
`ifdef IFU_ALIGN_CHECK_EN
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    for (int c = 0; c < 12; c++) begin
      redirect_valid = ($urandom_range(0, 2) == 0);
      redirect_pc    = {8'($urandom), 2'b00};
      step(1);
    end
    redirect_valid = 1'b0;
    reset = 1'b1;
    step(2);
    chk("fault_cleared", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b0;
    step(8);
`else
    chk("misaligned_addr", {22'd0, mem_addr}, 32'h040);
    step(8);
    chk("misaligned_pc", {22'd0, instr_pc}, 32'h040);
`endif

    step(2);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
